// File: rtl/cpu_trace_buffer_pkg.sv
// cpu_trace_buffer_pkg: shared state encoding, mode values and trace entry layout
package cpu_trace_buffer_pkg;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;
  localparam logic MODE_FREE = 1'b0;
  localparam logic MODE_TRIG = 1'b1;
  // Entry layout, LSB first: NZCV, WB_DATA, WB_REG, WB_VALID, INSTR, PC
  localparam int OFF_NZCV    = 0;
  localparam int OFF_WB_DATA = 4;
  function automatic int off_wb_reg(int data_w);
    return 4 + data_w;
  endfunction
  function automatic int off_wb_valid(int data_w, int reg_w);
    return 4 + data_w + reg_w;
  endfunction
  function automatic int off_instr(int data_w, int reg_w);
    return 5 + data_w + reg_w;
  endfunction
  function automatic int off_pc(int data_w, int reg_w);
    return 5 + 2 * data_w + reg_w;
  endfunction
  function automatic int entry_w(int pc_w, int data_w, int reg_w);
    return pc_w + 2 * data_w + 1 + reg_w + 4;
  endfunction
endpackage

// File: rtl/cpu_trace_buffer_trace_ram.sv
// trace_ram: DEPTH x W storage, synchronous write, asynchronous read, no reset
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: retirement trace capture (free-running or PC-triggered) with show-ahead pop port
module cpu_trace_buffer
  import cpu_trace_buffer_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 32,
  parameter int REG_W  = 4,
  parameter int DEPTH  = 16,
  parameter int OVF_W  = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       MODE,
  input  logic                       ARM,
  input  logic                       STOP,
  input  logic [PC_W-1:0]            TRIG_PC,
  input  logic                       RETIRE,
  input  logic [PC_W-1:0]            PC_I,
  input  logic [DATA_W-1:0]          INSTR_I,
  input  logic                       WB_VALID,
  input  logic [REG_W-1:0]           WB_REG,
  input  logic [DATA_W-1:0]          WB_DATA,
  input  logic [3:0]                 NZCV_I,
  input  logic                       RD_EN,
  output logic                       RD_VALID,
  output logic [PC_W-1:0]            RD_PC,
  output logic [DATA_W-1:0]          RD_INSTR,
  output logic                       RD_WB_VALID,
  output logic [REG_W-1:0]           RD_WB_REG,
  output logic [DATA_W-1:0]          RD_WB_DATA,
  output logic [3:0]                 RD_NZCV,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic [OVF_W-1:0]           OVF_CNT,
  output logic [1:0]                 STATE_O
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = entry_w(PC_W, DATA_W, REG_W);
  state_t            state, state_nx;
  logic              mode_q;
  logic [PC_W-1:0]   trig_q;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic [OVF_W-1:0]  ovf;
  logic [EW-1:0]     wr_entry, rd_entry, shown;
  logic              hit, wr, full, pop, last, rd_valid;
  assign hit  = RETIRE && PC_I == trig_q;
  // ARM takes priority over any retirement in the same cycle
  assign wr   = !ARM && ((state == S_CAPTURE && RETIRE) || (state == S_ARMED && hit));
  assign full = cnt == CW'(DEPTH);
  assign last = wr && mode_q == MODE_TRIG && cnt == CW'(DEPTH - 1);
  assign pop  = state == S_DONE && RD_EN && cnt != '0;
  assign wr_entry = {PC_I, INSTR_I, WB_VALID, WB_REG, WB_DATA, NZCV_I};
  trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
    .clk   (CLK),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );
  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end
  always_comb begin
    state_nx = ARM ? (MODE == MODE_FREE ? S_CAPTURE : S_ARMED) :
               state == S_ARMED ? (STOP ? S_DONE : hit ? S_CAPTURE : S_ARMED) :
               state == S_CAPTURE && (STOP || last) ? S_DONE : state;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
      mode_q <= 1'b0;
      trig_q <= '0;
    end else if (ARM) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= '0;
      mode_q <= MODE;
      trig_q <= TRIG_PC;
    end else if (wr) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (full) begin
        rd_ptr <= rd_ptr + AW'(1);
        ovf    <= &ovf ? ovf : ovf + OVF_W'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (pop) begin
      rd_ptr <= rd_ptr + AW'(1);
      cnt    <= cnt - CW'(1);
    end
  end
  always_comb begin
    rd_valid    = state == S_DONE && cnt != '0;
    shown       = rd_valid ? rd_entry : '0;
    RD_VALID    = rd_valid;
    RD_PC       = shown[off_pc(DATA_W, REG_W) +: PC_W];
    RD_INSTR    = shown[off_instr(DATA_W, REG_W) +: DATA_W];
    RD_WB_VALID = shown[off_wb_valid(DATA_W, REG_W)];
    RD_WB_REG   = shown[off_wb_reg(DATA_W) +: REG_W];
    RD_WB_DATA  = shown[OFF_WB_DATA +: DATA_W];
    RD_NZCV     = shown[OFF_NZCV +: 4];
    COUNT       = cnt;
    OVF_CNT     = ovf;
    STATE_O     = state;
  end
endmodule

// File: doc/cpu_trace_buffer.md
Name:
cpu_trace_buffer

Overview:
- Parametrised retirement-trace capture block for CPU_32 and its wider derivatives.
- Records one entry per retired instruction (PC, INSTR, writeback, NZCV) into a circular on-chip buffer.
- Capture is either free-running (keep last DEPTH) or PC-triggered (first DEPTH from trigger).
- Entries are drained afterwards through a valid/ready pop port, replacing per-cycle console dumps in benches and giving silicon-debug visibility.

Parameters:
- PC_W, 8, program counter width
- DATA_W, 32, instruction and register data width
- REG_W, 4, register index width (16 registers)
- DEPTH, 16, entries in buffer; power of two, >= 2
- OVF_W, 16, overflow counter width

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  synchronous, active-high reset
- MODE  in  1  0 = free-running circular, 1 = PC-triggered one-shot; sampled only on ARM
- ARM  in  1  pulse; clear buffer and start capture/arming
- STOP  in  1  pulse; end capture, enter DONE
- TRIG_PC  in  PC_W  trigger address for MODE=1; sampled on ARM
- RETIRE  in  1  one instruction retired this cycle
- PC_I  in  PC_W  PC of retiring instruction
- INSTR_I  in  DATA_W  retiring instruction word
- WB_VALID  in  1  retiring instruction wrote a register
- WB_REG  in  REG_W  destination register
- WB_DATA  in  DATA_W  value written
- NZCV_I  in  4  flags after retirement
- RD_EN  in  1  pop request
- RD_VALID  out  1  oldest entry present on RD_* outputs
- RD_PC  out  PC_W  entry PC
- RD_INSTR  out  DATA_W  entry instruction
- RD_WB_VALID  out  1  entry writeback flag
- RD_WB_REG  out  REG_W  entry destination
- RD_WB_DATA  out  DATA_W  entry writeback value
- RD_NZCV  out  4  entry flags
- COUNT  out  $clog2(DEPTH)+1  entries held
- OVF_CNT  out  OVF_W  entries overwritten (MODE=0), saturating
- STATE_O  out  2  current state, for debug

Behaviour:
- Reset: state IDLE, wr_ptr = rd_ptr = 0, COUNT = 0, OVF_CNT = 0, latched mode/trigger = 0. All RD_* outputs = 0 while RD_VALID = 0. Buffer storage is not reset.
- States:
  - IDLE: RETIRE ignored; ARM leads to ARMED (MODE=1) or CAPTURE (MODE=0).
  - ARMED: on RETIRE with PC_I == TRIG_PC, that instruction is written as entry 0 and the state goes to CAPTURE. STOP leads to DONE with COUNT = 0.
  - CAPTURE: each RETIRE writes at wr_ptr; the write is committed on the same edge and COUNT is updated by the next cycle.
    - MODE=1: the write making COUNT = DEPTH also moves to DONE.
    - MODE=0, full: write overwrites the oldest entry, rd_ptr advances with wr_ptr, COUNT stays DEPTH, OVF_CNT increments (saturating at all-ones).
    - STOP leads to DONE. A RETIRE in the STOP cycle is still written.
  - DONE: RETIRE ignored. RD_VALID = (COUNT != 0). RD_* are show-ahead (combinational from rd_ptr). RD_EN while RD_VALID pops: rd_ptr + 1, COUNT - 1, next entry visible the following cycle. RD_EN while empty is ignored.
- ARM in any non-IDLE state restarts: pointers, COUNT and OVF_CNT are cleared, and MODE/TRIG_PC are re-sampled.
- ARM and STOP in the same cycle: ARM wins.
- ARM and RETIRE in the same cycle: RETIRE is not recorded (capture starts next cycle).
- Pointers wrap DEPTH-1 to 0 using $clog2(DEPTH)-bit arithmetic.
- RD_VALID is forced to 0 outside DONE.
- RESET mid-capture or mid-drain discards everything and returns to IDLE.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=0, ARMED=1, CAPTURE=2, DONE=3
  - MODE_FREE=0, MODE_TRIG=1
  - entry field offsets, and ENTRY_W = PC_W + 2*DATA_W + 1 + REG_W + 4
- One sub-module, trace_ram: DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port.
- The control FSM, pointers and counters live in cpu_trace_buffer.

Test Plan:
- MODE=0, ARM, 5 RETIREs with PC 0..4, then STOP -> COUNT=5, OVF_CNT=0; 5 pops return PC 0..4 in order, then RD_VALID=0.
- MODE=0, DEPTH=16, 20 RETIREs with PC 0..19, then STOP -> COUNT=16, OVF_CNT=4; first pop PC=4, last pop PC=19.
- MODE=1, TRIG_PC=7, RETIREs with PC 0..30 -> no capture before PC 7; DONE after PC 22; pops return 7..22; later retirements are ignored.
- Entry with WB_VALID=1, WB_REG=3, WB_DATA=0xDEADBEEF, NZCV=4'b0100, INSTR=0x12345678 -> popped fields match bit-exactly.
- During CAPTURE after 3 entries, assert RESET for 1 cycle -> STATE_O=IDLE, COUNT=0, RD_VALID=0; a following ARM/STOP with no RETIRE gives COUNT=0.
- ARM and STOP together in CAPTURE -> state restarts (CAPTURE/ARMED), COUNT=0, OVF_CNT=0.
